// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: load-use, redirect and data-memory wait handling.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_stop,
    output logic        if_id_stop,
    output logic        if_id_clear,
    output logic        id_ex_stop,
    output logic        id_ex_clear,
    output logic        ex_mem_stop,
    output logic        ex_mem_clear,
    output logic        mem_wb_stop,
    output logic        mem_wb_clear,
    output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [31:0] load_use_count
`endif
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] TIMEOUT  = 2'd2;

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic freeze;
    logic load_use;
    logic row_redirect;
    logic row_load_use;

    always_comb begin
        freeze = ((state_q == RUN) && mem_req && !mem_ack)
              || ((state_q == MEM_WAIT) && !mem_ack)
              || (state_q == TIMEOUT);
        load_use = ex_mem_read && (ex_rd != 5'd0)
                && ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
    end

    // Prioritised stop/clear decode; everything is held low while in reset.
    always_comb begin
        pc_stop      = 1'b0;
        if_id_stop   = 1'b0;
        if_id_clear  = 1'b0;
        id_ex_stop   = 1'b0;
        id_ex_clear  = 1'b0;
        ex_mem_stop  = 1'b0;
        ex_mem_clear = 1'b0;
        mem_wb_stop  = 1'b0;
        mem_wb_clear = 1'b0;
        row_redirect = 1'b0;
        row_load_use = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                pc_stop     = 1'b1;
                if_id_stop  = 1'b1;
                id_ex_stop  = 1'b1;
                ex_mem_stop = 1'b1;
                mem_wb_stop = 1'b1;
            end else if (ex_redirect) begin
                // ID holds a wrong-path instruction, so any load-use match is moot.
                row_redirect = 1'b1;
                if_id_clear  = 1'b1;
                id_ex_clear  = 1'b1;
            end else if (load_use) begin
                row_load_use = 1'b1;
                pc_stop      = 1'b1;
                if_id_stop   = 1'b1;
                id_ex_clear  = 1'b1;
            end
        end
    end

    // Data-memory wait FSM; TIMEOUT only exits through reset.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == MAX_CNT) begin
                    state_d       = TIMEOUT;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            TIMEOUT: begin
                state_d = TIMEOUT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;
    logic [31:0] load_use_count_q, load_use_count_d;

    // Free-running event counters, wrapping modulo 2^32.
    always_comb begin
        stall_cycles_d   = stall_cycles_q + (pc_stop ? 32'd1 : 32'd0);
        flush_count_d    = flush_count_q + (row_redirect ? 32'd1 : 32'd0);
        load_use_count_d = load_use_count_q + (row_load_use ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q   <= '0;
            flush_count_q    <= '0;
            load_use_count_q <= '0;
        end else begin
            stall_cycles_q   <= stall_cycles_d;
            flush_count_q    <= flush_count_d;
            load_use_count_q <= load_use_count_d;
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign flush_count    = flush_count_q;
    assign load_use_count = load_use_count_q;
`endif

endmodule
